// File: rtl/mci_pkg.sv
// Shared MCI types: boot sequencer states, MCU reset reasons and the
// upstream MCU reset-request FSM states.
package mci_pkg;

  typedef enum logic [3:0] {
    BOOT_IDLE             = 4'd0,
    BOOT_OTP_FC           = 4'd1,
    BOOT_WAIT_CPTRA_GO    = 4'd2,
    BOOT_CPTRA            = 4'd3,
    BOOT_MCU              = 4'd4,
    BOOT_WAIT_MCU_RST_REQ = 4'd5,
    BOOT_HALT_MCU         = 4'd6,
    BOOT_WAIT_MCU_HALTED  = 4'd7,
    BOOT_RST_MCU          = 4'd8,
    BOOT_UNKNOWN          = 4'd15
  } mci_boot_fsm_state_e;

  typedef enum logic [1:0] {
    RST_REASON_NONE           = 2'd0,
    RST_REASON_FW_BOOT_UPD    = 2'd1,
    RST_REASON_FW_HITLESS_UPD = 2'd2
  } mci_rst_reason_e;

  typedef enum logic [2:0] {
    REQ_IDLE    = 3'd0,
    REQ_ASSERT  = 3'd1,
    REQ_HALTING = 3'd2,
    REQ_IN_RST  = 3'd3,
    REQ_DONE    = 3'd4
  } mci_rst_req_fsm_e;

  // The first reset after boot is a FW boot update; any later one is hitless.
  function automatic mci_rst_reason_e rst_reason_for(input logic mcu_reset_once);
    return mcu_reset_once ? RST_REASON_FW_HITLESS_UPD : RST_REASON_FW_BOOT_UPD;
  endfunction

endpackage

// File: rtl/mci_mcu_rst_req_ctrl.sv
// Turns a software MCU-reset pulse into the level request seen by the boot
// sequencer and tracks it to release. Halt timeout built under MCI_RST_REQ_TIMEOUT_EN.
module mci_mcu_rst_req_ctrl
  import mci_pkg::*;
#(
  parameter int HALT_TIMEOUT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          mci_rst_b,
  input  logic                          sw_rst_req_i,
  input  mci_boot_fsm_state_e           boot_fsm_i,
  input  logic                          mcu_reset_once_i,
  input  logic [HALT_TIMEOUT_WIDTH-1:0] halt_timeout_cfg_i,
  input  logic                          err_clr_i,
  output logic                          mcu_rst_req_o,
  output logic                          req_busy_o,
  output mci_rst_reason_e               rst_reason_o,
  output logic                          mcu_rst_done_o,
  output logic                          halt_timeout_err_o,
  output logic                          req_drop_err_o
);

  mci_rst_req_fsm_e state_q;

  logic active;
  logic accept;
  logic drop;
  logic abort;

  assign active = (state_q != REQ_IDLE);
  assign accept = !active && sw_rst_req_i;
  assign drop   = active && sw_rst_req_i;
  assign abort  = active && (boot_fsm_i == BOOT_IDLE);

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      // NOTE: every register here is updated with <= so all of them sample the
      // same pre-edge values; mixing in = would make results order-dependent.
      state_q        <= REQ_IDLE;
      mcu_rst_req_o  <= 1'b0;
      req_busy_o     <= 1'b0;
      rst_reason_o   <= RST_REASON_NONE;
      mcu_rst_done_o <= 1'b0;
      req_drop_err_o <= 1'b0;
    end else begin
      mcu_rst_done_o <= 1'b0;

      // NOTE: the set term is tested first so a drop in the clearing cycle survives.
      if (drop) begin
        req_drop_err_o <= 1'b1;
      end else if (err_clr_i) begin
        req_drop_err_o <= 1'b0;
      end

      // A sequencer warm reset abandons the request without a done pulse.
      if (abort) begin
        state_q       <= REQ_IDLE;
        mcu_rst_req_o <= 1'b0;
        req_busy_o    <= 1'b0;
      end else begin
        case (state_q)
          REQ_IDLE: begin
            if (accept) begin
              state_q       <= REQ_ASSERT;
              mcu_rst_req_o <= 1'b1;
              req_busy_o    <= 1'b1;
              rst_reason_o  <= rst_reason_for(mcu_reset_once_i);
            end
          end
          REQ_ASSERT: begin
            if (boot_fsm_i == BOOT_HALT_MCU) begin
              state_q       <= REQ_HALTING;
              mcu_rst_req_o <= 1'b0;
            end
          end
          REQ_HALTING: begin
            if (boot_fsm_i == BOOT_RST_MCU) state_q <= REQ_IN_RST;
          end
          REQ_IN_RST: begin
            if (boot_fsm_i == BOOT_MCU) state_q <= REQ_DONE;
          end
          REQ_DONE: begin
            state_q        <= REQ_IDLE;
            req_busy_o     <= 1'b0;
            mcu_rst_done_o <= 1'b1;
          end
          default: begin
            state_q       <= REQ_IDLE;
            mcu_rst_req_o <= 1'b0;
            req_busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MCI_RST_REQ_TIMEOUT_EN
  logic [HALT_TIMEOUT_WIDTH-1:0] tmo_cnt_q;
  logic                          waiting;
  logic                          tmo_hit;

  assign waiting = (state_q == REQ_ASSERT) || (state_q == REQ_HALTING);
  assign tmo_hit = waiting && (halt_timeout_cfg_i != '0) && (tmo_cnt_q == halt_timeout_cfg_i);

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      tmo_cnt_q          <= '0;
      halt_timeout_err_o <= 1'b0;
    end else begin
      if (accept) begin
        tmo_cnt_q <= '0;
      end else if (waiting && (tmo_cnt_q != '1)) begin
        tmo_cnt_q <= tmo_cnt_q + {{(HALT_TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
      end

      if (tmo_hit) begin
        halt_timeout_err_o <= 1'b1;
      end else if (err_clr_i) begin
        halt_timeout_err_o <= 1'b0;
      end
    end
  end
`else
  logic unused_halt_timeout_cfg;
  assign unused_halt_timeout_cfg = ^halt_timeout_cfg_i;
  assign halt_timeout_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mci_mcu_rst_req_ctrl.sv
// Directed bench for mci_mcu_rst_req_ctrl; expected timeout behaviour follows
// whether MCI_RST_REQ_TIMEOUT_EN is defined for the build.
module tb_mci_mcu_rst_req_ctrl;
  import mci_pkg::*;

  localparam int W = 16;

`ifdef MCI_RST_REQ_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                mci_rst_b;
  logic                sw_rst_req;
  mci_boot_fsm_state_e boot_fsm;
  logic                mcu_reset_once;
  logic [W-1:0]        halt_timeout_cfg;
  logic                err_clr;
  logic                mcu_rst_req;
  logic                req_busy;
  mci_rst_reason_e     rst_reason;
  logic                mcu_rst_done;
  logic                halt_timeout_err;
  logic                req_drop_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mci_mcu_rst_req_ctrl #(.HALT_TIMEOUT_WIDTH(W)) dut (
    .clk                (clk),
    .mci_rst_b          (mci_rst_b),
    .sw_rst_req_i       (sw_rst_req),
    .boot_fsm_i         (boot_fsm),
    .mcu_reset_once_i   (mcu_reset_once),
    .halt_timeout_cfg_i (halt_timeout_cfg),
    .err_clr_i          (err_clr),
    .mcu_rst_req_o      (mcu_rst_req),
    .req_busy_o         (req_busy),
    .rst_reason_o       (rst_reason),
    .mcu_rst_done_o     (mcu_rst_done),
    .halt_timeout_err_o (halt_timeout_err),
    .req_drop_err_o     (req_drop_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_flow(input logic once, input logic [1:0] exp_reason);
    mcu_reset_once = once;
    boot_fsm       = BOOT_MCU;
    sw_rst_req     = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("flow_req_rise", 32'(mcu_rst_req), 1);
    check("flow_busy_rise", 32'(req_busy), 1);
    check("flow_reason", 32'(rst_reason), 32'(exp_reason));
    boot_fsm = BOOT_WAIT_MCU_RST_REQ;
    tick();
    check("flow_req_held", 32'(mcu_rst_req), 1);
    boot_fsm = BOOT_HALT_MCU;
    tick();
    check("flow_req_fall", 32'(mcu_rst_req), 0);
    boot_fsm = BOOT_WAIT_MCU_HALTED;
    tick();
    check("flow_busy_halted", 32'(req_busy), 1);
    boot_fsm = BOOT_RST_MCU;
    tick();
    check("flow_no_done_rst", 32'(mcu_rst_done), 0);
    boot_fsm = BOOT_MCU;
    tick();
    check("flow_no_done_early", 32'(mcu_rst_done), 0);
    tick();
    check("flow_done_pulse", 32'(mcu_rst_done), 1);
    check("flow_busy_clear", 32'(req_busy), 0);
    tick();
    check("flow_done_once", 32'(mcu_rst_done), 0);
    check("flow_reason_kept", 32'(rst_reason), 32'(exp_reason));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mci_rst_b        = 1'b0;
    sw_rst_req       = 1'b0;
    boot_fsm         = BOOT_MCU;
    mcu_reset_once   = 1'b0;
    halt_timeout_cfg = '0;
    err_clr          = 1'b0;
    #1;
    check("rst_req", 32'(mcu_rst_req), 0);
    check("rst_busy", 32'(req_busy), 0);
    check("rst_reason", 32'(rst_reason), 0);
    check("rst_done", 32'(mcu_rst_done), 0);
    check("rst_tmo", 32'(halt_timeout_err), 0);
    check("rst_drop", 32'(req_drop_err), 0);
    tick();
    tick();
    mci_rst_b = 1'b1;
    tick();

    // First FW boot update, then a hitless update.
    run_flow(1'b0, 2'd1);
    run_flow(1'b1, 2'd2);

    // Timeout of 10 while the sequencer sits in BOOT_HALT_MCU.
    halt_timeout_cfg = 16'd10;
    mcu_reset_once   = 1'b1;
    boot_fsm         = BOOT_HALT_MCU;
    sw_rst_req       = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (10) tick();
    check("tmo_not_yet", 32'(halt_timeout_err), 0);
    tick();
    check("tmo_set", 32'(halt_timeout_err), 32'(TMO_EXP));
    check("tmo_still_busy", 32'(req_busy), 1);
    boot_fsm = BOOT_RST_MCU;
    tick();
    boot_fsm = BOOT_MCU;
    tick();
    tick();
    check("tmo_flow_done", 32'(mcu_rst_done), 1);
    check("tmo_sticky", 32'(halt_timeout_err), 32'(TMO_EXP));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_cleared", 32'(halt_timeout_err), 0);

    // Timeout disabled by a zero limit.
    halt_timeout_cfg = '0;
    boot_fsm         = BOOT_HALT_MCU;
    sw_rst_req       = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (15) tick();
    check("tmo_cfg0_none", 32'(halt_timeout_err), 0);
    boot_fsm = BOOT_RST_MCU;
    tick();
    boot_fsm = BOOT_MCU;
    tick();
    tick();
    check("tmo_cfg0_done", 32'(mcu_rst_done), 1);
    tick();

    // Drops while in REQ_IN_RST and in the REQ_DONE cycle.
    mcu_reset_once = 1'b1;
    boot_fsm       = BOOT_WAIT_MCU_RST_REQ;
    sw_rst_req     = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    boot_fsm   = BOOT_HALT_MCU;
    tick();
    boot_fsm = BOOT_RST_MCU;
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("drop_set", 32'(req_drop_err), 1);
    check("drop_no_req", 32'(mcu_rst_req), 0);
    check("drop_busy", 32'(req_busy), 1);
    sw_rst_req = 1'b1;
    err_clr    = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("drop_set_wins", 32'(req_drop_err), 1);
    tick();
    err_clr = 1'b0;
    check("drop_cleared", 32'(req_drop_err), 0);
    boot_fsm = BOOT_MCU;
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("drop_done_pulse", 32'(mcu_rst_done), 1);
    check("drop_in_done", 32'(req_drop_err), 1);
    tick();
    check("drop_done_no_req", 32'(mcu_rst_req), 0);
    check("drop_done_idle", 32'(req_busy), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Sequencer warm reset during REQ_HALTING.
    mcu_reset_once = 1'b0;
    boot_fsm       = BOOT_WAIT_MCU_RST_REQ;
    sw_rst_req     = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    boot_fsm   = BOOT_HALT_MCU;
    tick();
    check("abort_halting", 32'(req_busy), 1);
    boot_fsm = BOOT_IDLE;
    tick();
    check("abort_idle", 32'(req_busy), 0);
    check("abort_no_done", 32'(mcu_rst_done), 0);
    check("abort_reason", 32'(rst_reason), 1);
    tick();
    check("abort_no_done_later", 32'(mcu_rst_done), 0);
    boot_fsm = BOOT_MCU;
    tick();

    // Asynchronous reset while the request is asserted.
    mcu_reset_once = 1'b1;
    sw_rst_req     = 1'b1;
    tick();
    tick();
    sw_rst_req = 1'b0;
    check("arst_pre_req", 32'(mcu_rst_req), 1);
    check("arst_pre_drop", 32'(req_drop_err), 1);
    #2;
    mci_rst_b = 1'b0;
    #1;
    check("arst_req", 32'(mcu_rst_req), 0);
    check("arst_busy", 32'(req_busy), 0);
    check("arst_reason", 32'(rst_reason), 0);
    check("arst_drop", 32'(req_drop_err), 0);
    tick();
    mci_rst_b = 1'b1;
    repeat (4) tick();
    check("arst_no_done", 32'(mcu_rst_done), 0);
    check("arst_idle", 32'(req_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mci_mcu_rst_req_ctrl.md
# mci_mcu_rst_req_ctrl

Upstream request controller for the MCI boot sequencer's MCU reset path. It turns a single-cycle software MCU-reset request into the level `mcu_rst_req` the sequencer consumes. It tracks the sequencer through halt, reset and release, and records the reset reason (first FW boot update vs. hitless update). It also flags a halt-handshake timeout and pulses completion when the MCU is released.

## Interface
Parameters
- `HALT_TIMEOUT_WIDTH`, 16: width of the halt-timeout counter and its config input.

Ports
- `clk`, in, 1: MCI clock.
- `mci_rst_b`, in, 1: MCI reset; asynchronous, active-low.
- `sw_rst_req_i`, in, 1: one-cycle pulse from the CSR write requesting an MCU reset.
- `boot_fsm_i`, in, `mci_boot_fsm_state_e`: current boot sequencer state.
- `mcu_reset_once_i`, in, 1: MCU has been reset by the sequencer before.
- `halt_timeout_cfg_i`, in, `HALT_TIMEOUT_WIDTH`: timeout limit in cycles; 0 disables the timeout.
- `err_clr_i`, in, 1: pulse that clears the sticky error flags.
- `mcu_rst_req_o`, out, 1: reset request to the boot sequencer.
- `req_busy_o`, out, 1: a request is in flight (FSM not in `REQ_IDLE`).
- `rst_reason_o`, out, `mci_rst_reason_e`: reason recorded for the last accepted request.
- `mcu_rst_done_o`, out, 1: one-cycle pulse when the MCU is released after a reset.
- `halt_timeout_err_o`, out, 1: sticky flag; halt/reset not reached within the limit.
- `req_drop_err_o`, out, 1: sticky flag; a request arrived while busy.

## Operation
FSM states, reset state `REQ_IDLE`:
- `REQ_IDLE`: when `sw_rst_req_i` is high, capture the reason, clear the timeout counter and go to `REQ_ASSERT`.
  - Reason is `RST_REASON_FW_BOOT_UPD` if `!mcu_reset_once_i`, otherwise `RST_REASON_FW_HITLESS_UPD`.
- `REQ_ASSERT`: `mcu_rst_req_o` = 1. When `boot_fsm_i == BOOT_HALT_MCU`, go to `REQ_HALTING`.
  - The request is held as long as needed, including while the sequencer has not yet reached `BOOT_WAIT_MCU_RST_REQ`.
- `REQ_HALTING`: `mcu_rst_req_o` = 0. When `boot_fsm_i == BOOT_RST_MCU`, go to `REQ_IN_RST`.
- `REQ_IN_RST`: when `boot_fsm_i == BOOT_MCU`, go to `REQ_DONE`.
- `REQ_DONE`: `mcu_rst_done_o` = 1 for one cycle, then go to `REQ_IDLE`.

Abort rule:
- In any non-idle state, `boot_fsm_i == BOOT_IDLE` (sequencer warm reset) sends the FSM to `REQ_IDLE`.
- No done pulse is produced; `rst_reason_o` is retained.

Drop rule:
- `sw_rst_req_i` in any state other than `REQ_IDLE` is ignored and sets `req_drop_err_o`.
- This includes the `REQ_DONE` cycle.

Timeout counter:
- Increments in `REQ_ASSERT` and `REQ_HALTING`, saturating at all-ones.
- When count == `halt_timeout_cfg_i` and the config is nonzero, set `halt_timeout_err_o`.
- The FSM keeps waiting; a timeout does not abort the request.

Error flag clear:
- `err_clr_i` clears both sticky flags.
- If a set and `err_clr_i` occur in the same cycle, the set wins.

Reset values: all outputs 0, `rst_reason_o` = `RST_REASON_NONE`, FSM `REQ_IDLE`, counter 0.

## Timing
- All outputs are registered.
- `mcu_rst_req_o` rises 1 cycle after the accepting `sw_rst_req_i`.
- `mcu_rst_req_o` falls 1 cycle after `boot_fsm_i` is first sampled as `BOOT_HALT_MCU`.
- `rst_reason_o` updates 1 cycle after acceptance.
- `mcu_rst_done_o` is high exactly one cycle, 2 cycles after `boot_fsm_i` is first sampled as `BOOT_MCU`.
- `halt_timeout_err_o` sets the cycle after count == limit.
- `mci_rst_b` asserted mid-operation clears everything asynchronously; no done pulse follows.

## Configuration
- `MCI_RST_REQ_TIMEOUT_EN` defined: the timeout counter and `halt_timeout_err_o` logic are present.
- Undefined: no counter is built, `halt_timeout_err_o` is tied 0 and `halt_timeout_cfg_i` is unused. All other behaviour is identical.

## Structure
- `mci_pkg` owns:
  - the `mci_rst_reason_e` enum: `RST_REASON_NONE`=0, `RST_REASON_FW_BOOT_UPD`=1, `RST_REASON_FW_HITLESS_UPD`=2;
  - the request-FSM state enum `mci_rst_req_fsm_e`.
- `mci_boot_fsm_state_e` is reused from `mci_pkg`.
- Single flat module; the counter is inline, no sub-module.

## Test plan
- First reset: `mcu_reset_once_i`=0, pulse `sw_rst_req_i`, then step `boot_fsm_i` through `BOOT_WAIT_MCU_RST_REQ`→`BOOT_HALT_MCU`→`BOOT_WAIT_MCU_HALTED`→`BOOT_RST_MCU`→`BOOT_MCU`.
  - Required: `mcu_rst_req_o` high until HALT+1; `rst_reason_o`=1; one `mcu_rst_done_o` pulse; `req_busy_o` 0 afterwards.
- Second reset, same sequence with `mcu_reset_once_i`=1 -> `rst_reason_o`=2.
- Timeout: `halt_timeout_cfg_i`=10, hold `boot_fsm_i` in `BOOT_HALT_MCU`.
  - Required: `halt_timeout_err_o` sets on cycle 11 after assertion and the flow still completes.
  - Repeat with config 0 -> no error. With the macro undefined -> never set.
- Drop: second `sw_rst_req_i` while in `REQ_IN_RST` -> `req_drop_err_o`=1 and no extra request.
  - `err_clr_i` in the same cycle as a new drop -> the flag stays 1.
- Abort: `boot_fsm_i`=`BOOT_IDLE` during `REQ_HALTING` -> `REQ_IDLE` next cycle, no done pulse, reason retained.
- Async reset: assert `mci_rst_b` during `REQ_ASSERT` -> all outputs 0 immediately; reason `NONE`.
